// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl -- RV32I instruction-decode stage
//
// Takes one instruction from fetch per valid/ready handshake and presents
// registered execute/writeback mux selects, ALU sub-op, register indices,
// immediate and PC to execute one cycle later. Execute backpressures through
// ex_ready. A flush kills both the held instruction and the one on the input.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   if_valid/if_instr/if_pc     fetch side request
//   id_ready                    stage can take an instruction this cycle
//   flush                       branch/jump redirect kill
//   ex_ready/ex_valid           execute side handshake
//   alu_mux_sel, x_op1_mux_sel,
//   x_op2_mux_sel, w_mux_sel    datapath selects (proc_pkg types)
//   alu_sub, alu_funct3         ALU sub-op control
//   rs1_addr/rs2_addr/rd_addr   register indices
//   imm, pc_d1                  sign-extended immediate, PC of held instr
//   reg_we                      rd write enable (never set for rd == x0)
//   illegal_instr               only with DECODE_ILLEGAL_TRAP_EN defined
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : illegal encodings set illegal_instr and still reach execute
//   undefined : illegal encodings travel to execute as a NOP
// -----------------------------------------------------------------------------

package proc_pkg;
    typedef enum logic [1:0] {
        ALU_ARITH            = 2'd0,
        ALU_LOGIC            = 2'd1,
        ALU_SHIFT            = 2'd2,
        ALU_PC_VAL_PLUS_4_D2 = 2'd3
    } alu_mux_sel_t;

    typedef enum logic {
        OP1_REG1_DATA = 1'b0,
        OP1_PC_VAL_D1 = 1'b1
    } x_op1_mux_sel_t;

    typedef enum logic {
        OP2_REG2_DATA  = 1'b0,
        OP2_IMM_SIGNED = 1'b1
    } x_op2_mux_sel_t;

    typedef enum logic {
        W_ALU = 1'b0,
        W_MEM = 1'b1
    } w_mux_sel_t;
endpackage

module decode_ctrl
    import proc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [31:0]          if_instr,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 id_ready,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output alu_mux_sel_t         alu_mux_sel,
    output x_op1_mux_sel_t       x_op1_mux_sel,
    output x_op2_mux_sel_t       x_op2_mux_sel,
    output w_mux_sel_t           w_mux_sel,
    output logic                 alu_sub,
    output logic [2:0]           alu_funct3,
    output logic [NREG_BITS-1:0] rs1_addr,
    output logic [NREG_BITS-1:0] rs2_addr,
    output logic [NREG_BITS-1:0] rd_addr,
    output logic [XLEN-1:0]      imm,
    output logic [XLEN-1:0]      pc_d1,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic                 reg_we
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        alu_mux_sel_t         alu;
        x_op1_mux_sel_t       op1;
        x_op2_mux_sel_t       op2;
        w_mux_sel_t           wsel;
        logic                 sub;
        logic [2:0]           f3;
        logic [NREG_BITS-1:0] rs1;
        logic [NREG_BITS-1:0] rs2;
        logic [NREG_BITS-1:0] rd;
        logic [XLEN-1:0]      imm;
        logic                 we;
    } ctrl_t;

    // Reset value and the shape of a NOP are the same bundle.
    localparam ctrl_t CTRL_NOP = '{
        alu:  ALU_ARITH,
        op1:  OP1_REG1_DATA,
        op2:  OP2_REG2_DATA,
        wsel: W_ALU,
        sub:  1'b0,
        f3:   3'b000,
        rs1:  '0,
        rs2:  '0,
        rd:   '0,
        imm:  '0,
        we:   1'b0
    };

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [NREG_BITS-1:0] rs1_f, rs2_f, rd_f;
    logic [31:0]          imm_i, imm_u, imm_j;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1_f  = NREG_BITS'(if_instr[19:15]);
    assign rs2_f  = NREG_BITS'(if_instr[24:20]);
    assign rd_f   = NREG_BITS'(if_instr[11:7]);

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Result class for register/immediate ALU ops
    alu_mux_sel_t alu_cls;
    always_comb begin
        case (funct3)
            3'b001, 3'b101:         alu_cls = ALU_SHIFT;
            3'b100, 3'b110, 3'b111: alu_cls = ALU_LOGIC;
            default:                alu_cls = ALU_ARITH;
        endcase
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t ctrl_d;
    logic  legal;

    always_comb begin
        ctrl_d = CTRL_NOP;
        legal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                // funct7[5] only selects SUB / SRA; anywhere else it's illegal
                legal      = (funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 &&
                              (funct3 == 3'b000 || funct3 == 3'b101));
                ctrl_d.alu = alu_cls;
                ctrl_d.sub = if_instr[30];
                ctrl_d.f3  = funct3;
                ctrl_d.rs1 = rs1_f;
                ctrl_d.rs2 = rs2_f;
                ctrl_d.rd  = rd_f;
                ctrl_d.we  = 1'b1;
            end
            OPC_OP_IMM: begin
                // Immediate shifts carry funct7 in imm[11:5]
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) ||
                                     (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                ctrl_d.alu = alu_cls;
                ctrl_d.op2 = OP2_IMM_SIGNED;
                ctrl_d.sub = (funct3 == 3'b101) && if_instr[30];
                ctrl_d.f3  = funct3;
                ctrl_d.rs1 = rs1_f;
                ctrl_d.rd  = rd_f;
                ctrl_d.imm = sext(imm_i);
                ctrl_d.we  = 1'b1;
            end
            OPC_LUI: begin
                // rd = x0 + imm, so rs1 stays 0
                legal      = 1'b1;
                ctrl_d.op2 = OP2_IMM_SIGNED;
                ctrl_d.rd  = rd_f;
                ctrl_d.imm = sext(imm_u);
                ctrl_d.we  = 1'b1;
            end
            OPC_AUIPC: begin
                legal      = 1'b1;
                ctrl_d.op1 = OP1_PC_VAL_D1;
                ctrl_d.op2 = OP2_IMM_SIGNED;
                ctrl_d.rd  = rd_f;
                ctrl_d.imm = sext(imm_u);
                ctrl_d.we  = 1'b1;
            end
            OPC_JAL: begin
                legal      = 1'b1;
                ctrl_d.alu = ALU_PC_VAL_PLUS_4_D2;
                ctrl_d.rd  = rd_f;
                ctrl_d.imm = sext(imm_j);
                ctrl_d.we  = 1'b1;
            end
            OPC_JALR: begin
                legal      = (funct3 == 3'b000);
                ctrl_d.alu = ALU_PC_VAL_PLUS_4_D2;
                ctrl_d.rs1 = rs1_f;
                ctrl_d.rd  = rd_f;
                ctrl_d.imm = sext(imm_i);
                ctrl_d.we  = 1'b1;
            end
            default: ;
        endcase

        if (!legal)
            ctrl_d = CTRL_NOP;
        // x0 is hardwired; never request a write to it
        if (ctrl_d.rd == '0)
            ctrl_d.we = 1'b0;
    end

    // ------------------------------------------------------------------
    // Handshake and output registers
    // ------------------------------------------------------------------
    ctrl_t           ctrl_q;
    logic            ex_valid_q;
    logic [XLEN-1:0] pc_q;
    logic            load;

    assign id_ready = !ex_valid_q || ex_ready;
    assign load     = if_valid && id_ready && !flush;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            pc_q       <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else if (flush) begin
            // Remaining fields keep stale data; ex_valid gates them
            ex_valid_q <= 1'b0;
            ctrl_q.we  <= 1'b0;
        end else if (load) begin
            ex_valid_q <= 1'b1;
            ctrl_q     <= ctrl_d;
            pc_q       <= if_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q  <= !legal;
`endif
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign alu_mux_sel   = ctrl_q.alu;
    assign x_op1_mux_sel = ctrl_q.op1;
    assign x_op2_mux_sel = ctrl_q.op2;
    assign w_mux_sel     = ctrl_q.wsel;
    assign alu_sub       = ctrl_q.sub;
    assign alu_funct3    = ctrl_q.f3;
    assign rs1_addr      = ctrl_q.rs1;
    assign rs2_addr      = ctrl_q.rs2;
    assign rd_addr       = ctrl_q.rd;
    assign imm           = ctrl_q.imm;
    assign pc_d1         = pc_q;
    assign reg_we        = ctrl_q.we;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`endif

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Instruction-decode pipeline stage. Generates the proc_pkg datapath selects consumed by the execute/writeback muxes: alu_mux_sel_t, x_op1_mux_sel_t, x_op2_mux_sel_t and w_mux_sel_t.
- Sits between fetch and execute. Accepts one 32-bit RV32I instruction per valid/ready transfer and presents registered control plus operand fields to execute.
- Supports backpressure from execute and flush from branch/jump resolution.

Parameters:
- XLEN, 32, datapath/PC width.
- NREG_BITS, 5, register index width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- id_ready  out  1  stage can accept an instruction this cycle.
- flush  in  1  kill the held instruction and the one on the input.
- ex_ready  in  1  execute accepts ex_valid this cycle.
- ex_valid  out  1  registered control below is valid.
- alu_mux_sel  out  alu_mux_sel_t  ALU result select.
- x_op1_mux_sel  out  x_op1_mux_sel_t  operand 1 select.
- x_op2_mux_sel  out  x_op2_mux_sel_t  operand 2 select.
- w_mux_sel  out  w_mux_sel_t  writeback select.
- alu_sub  out  1  subtract / arithmetic shift (funct7[5]).
- alu_funct3  out  3  funct3 passthrough for ARITH/LOGIC/SHIFT sub-op.
- rs1_addr, rs2_addr, rd_addr  out  NREG_BITS each  register indices.
- imm  out  XLEN  sign-extended immediate (I/U/J format per opcode).
- pc_d1  out  XLEN  PC of the held instruction.
- reg_we  out  1  rd write enable; forced 0 when rd_addr==0.

Behaviour:
- Reset values (async, rst_n low):
  - ex_valid=0, reg_we=0, alu_sub=0.
  - All address, imm, pc_d1 and funct3 outputs = 0.
  - Selects: ARITH, REG1_DATA, REG2_DATA, ALU.
- Ready: id_ready = !ex_valid || ex_ready (combinational). No combinational path from if_valid to id_ready.
- Load: on if_valid && id_ready && !flush, all output registers load the decode of if_instr next cycle and ex_valid<=1. Latency is 1 cycle.
- Drain: when ex_valid && ex_ready and there is no new load, ex_valid<=0. Other outputs hold their last value.
- Hold: when ex_valid && !ex_ready, every output is held stable.
- Flush: highest priority. Next cycle ex_valid<=0 regardless of if_valid or ex_ready, and no load occurs. Register contents other than ex_valid and reg_we are don't-care.
- Decode table (w_mux_sel = ALU for every entry):
  - OP 0110011:
    - op2=REG2_DATA, op1=REG1_DATA.
    - funct3 000/010/011 -> ARITH; 100/110/111 -> LOGIC; 001/101 -> SHIFT.
    - alu_sub=funct7[5], legal only for funct3 000/101. reg_we=1.
  - OP-IMM 0010011:
    - Same selects as OP but op2=IMM_SIGNED, I-imm.
    - alu_sub=funct7[5] only for funct3 101, else 0.
  - LUI 0110111: ARITH, op1=REG1_DATA, rs1_addr forced 0, op2=IMM_SIGNED, U-imm.
  - AUIPC 0010111: ARITH, op1=PC_VAL_D1, op2=IMM_SIGNED, U-imm.
  - JAL 1101111: alu_mux_sel=ALU_PC_VAL_PLUS_4_D2, J-imm, reg_we=1.
  - JALR 1100111 (funct3=000): alu_mux_sel=ALU_PC_VAL_PLUS_4_D2, op1=REG1_DATA, I-imm, reg_we=1.
  - Any other opcode/funct combination is illegal (see Optional Feature).
- Immediates: sign-extended from bit 31 to XLEN. U-imm = {instr[31:12],12'b0}.
- reg_we: rd_addr==0 forces reg_we=0 for every instruction.
- Simultaneous events:
  - flush with a load: flush wins.
  - Drain with a load in the same cycle: the new instruction loads and ex_valid stays 1.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Extra output port illegal_instr (1 bit), registered with the other outputs, reset 0.
  - Set to 1 for an illegal decode. reg_we is forced 0 and ex_valid still asserts so execute can trap.
- Undefined:
  - Port absent.
  - Illegal instructions decode as NOP: ex_valid=1, reg_we=0, selects at their reset values.

Test Plan:
- Reset mid-stream: rst_n low while ex_valid=1 -> outputs go to reset values immediately, without waiting for clk; id_ready=1 after release.
- ADD x3,x1,x2 (0x002081B3) then SUB (0x402081B3) back-to-back with ex_ready=1:
  - Cycle +1: ARITH, REG2_DATA, rd=3, alu_sub=0.
  - Cycle +2: alu_sub=1.
  - ex_valid stays 1.
- ADDI x1,x0,5 (0x00500093) with ex_ready=0 for 3 cycles:
  - id_ready=0 and imm=5 are held.
  - A second instruction on the input is not accepted until ex_ready=1.
- JAL x1,8 (0x008000EF) at pc 0x100 -> ALU_PC_VAL_PLUS_4_D2, imm=8, pc_d1=0x100, reg_we=1. The same encoding with rd=0 gives reg_we=0.
- AUIPC x5,1 (0x00001297) presented with flush=1 -> ex_valid=0 next cycle. Re-presented without flush -> PC_VAL_D1, IMM_SIGNED, imm=0x1000.
- 0xFFFFFFFF:
  - With DECODE_ILLEGAL_TRAP_EN: illegal_instr=1, reg_we=0.
  - Without it: NOP decode with ex_valid=1, reg_we=0.
